// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/capture blocks.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serial_state_e;

  // Bit-order selectors for serial blocks.
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage : serial_pkg

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a word over valid/ready and shifts
// it out one bit per shift_en strobe, flagging first and last bits of each frame.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned        CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam bit                 LSB_MODE = (MSB_FIRST == ORDER_LSB_FIRST);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic             last_bit;
  logic             in_shift;

  assign in_shift     = (state_q == SHIFT);
  assign last_bit     = (cnt_q == LAST_CNT);
  assign sreg_shifted = LSB_MODE ? {1'b0, sreg_q[WIDTH-1:1]}
                                 : {sreg_q[WIDTH-2:0], 1'b0};

  // Accept in IDLE, or on the final bit's strobe so frames stream with no gap.
  assign load_ready = !rst && (!in_shift || (shift_en && last_bit));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          sreg_d  = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!last_bit) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (load_valid) begin
            sreg_d = load_data;
            cnt_d  = '0;
          end else begin
            // Final shift leaves sreg all-zero so sout idles low.
            sreg_d  = sreg_shifted;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sout       = LSB_MODE ? sreg_q[0] : sreg_q[WIDTH-1];
  assign sout_valid = in_shift;
  assign sout_first = in_shift && (cnt_q == '0);
  assign sout_last  = in_shift && last_bit;
  assign busy       = in_shift;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench: a 4-bit MSB-first and an 8-bit LSB-first instance.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_en;

  logic [3:0] load_data4;
  logic       load_valid4, load_ready4, sout4, sout_valid4, sout_first4, sout_last4, busy4;
  logic [7:0] load_data8;
  logic       load_valid8, load_ready8, sout8, sout_valid8, sout_first8, sout_last8, busy8;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .load_data  (load_data4),
    .load_valid (load_valid4),
    .load_ready (load_ready4),
    .sout       (sout4),
    .sout_valid (sout_valid4),
    .sout_first (sout_first4),
    .sout_last  (sout_last4),
    .busy       (busy4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .load_data  (load_data8),
    .load_valid (load_valid8),
    .load_ready (load_ready8),
    .sout       (sout8),
    .sout_valid (sout_valid8),
    .sout_first (sout_first8),
    .sout_last  (sout_last8),
    .busy       (busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; shift_en = 1'b1;
    load_valid4 = 1'b1; load_data4 = 4'hF;
    load_valid8 = 1'b1; load_data8 = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({load_ready4, sout4, sout_valid4, busy4} !== 4'b0000)
        $display("FAIL reset4 cyc%0d: ready/sout/valid/busy=%b required 0000", c,
                 {load_ready4, sout4, sout_valid4, busy4});
      else passed++;
      checks++;
      if ({load_ready8, sout8, sout_valid8, busy8} !== 4'b0000)
        $display("FAIL reset8 cyc%0d: ready/sout/valid/busy=%b required 0000", c,
                 {load_ready8, sout8, sout_valid8, busy8});
      else passed++;
    end
    load_valid4 = 1'b0; load_valid8 = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({load_ready4, sout4, sout_valid4, sout_first4, sout_last4} !== 5'b10000)
      $display("FAIL post_reset4: ready/sout/valid/first/last=%b required 10000",
               {load_ready4, sout4, sout_valid4, sout_first4, sout_last4});
    else passed++;
    checks++;
    if ({load_ready8, sout8, sout_valid8, sout_first8, sout_last8} !== 5'b10000)
      $display("FAIL post_reset8: ready/sout/valid/first/last=%b required 10000",
               {load_ready8, sout8, sout_valid8, sout_first8, sout_last8});
    else passed++;
  endtask

  task automatic test_single_msb();
    logic exp_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    shift_en = 1'b1; load_valid4 = 1'b1; load_data4 = 4'b1011;
    checks++;
    if (load_ready4 !== 1'b1) $display("FAIL single_accept: ready=%b required 1", load_ready4);
    else passed++;
    tick();
    load_valid4 = 1'b0; load_data4 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sout_valid4, sout4, sout_first4, sout_last4} !==
          {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 3)})
        $display("FAIL single_bit%0d: valid/sout/first/last=%b required %b", i,
                 {sout_valid4, sout4, sout_first4, sout_last4},
                 {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 3)});
      else passed++;
      tick();
    end
    checks++;
    if ({sout_valid4, busy4, sout4, load_ready4} !== 4'b0001)
      $display("FAIL single_idle: valid/busy/sout/ready=%b required 0001",
               {sout_valid4, busy4, sout4, load_ready4});
    else passed++;
  endtask

  task automatic test_lsb_loopback();
    logic       exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] cap = 8'h00;
    shift_en = 1'b1; load_valid8 = 1'b1; load_data8 = 8'hA5;
    tick();
    load_valid8 = 1'b0; load_data8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sout_valid8, sout8, sout_first8, sout_last8} !==
          {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 7)})
        $display("FAIL lsb_bit%0d: valid/sout/first/last=%b required %b", i,
                 {sout_valid8, sout8, sout_first8, sout_last8},
                 {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 7)});
      else passed++;
      if (sout_valid8) cap = {sout8, cap[7:1]};
      tick();
    end
    checks++;
    if (cap !== 8'hA5) $display("FAIL lsb_capture: rebuilt=%h required a5", cap);
    else passed++;
    checks++;
    if ({sout_valid8, sout8} !== 2'b00)
      $display("FAIL lsb_idle: valid/sout=%b required 00", {sout_valid8, sout8});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic exp_bits [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    shift_en = 1'b1; load_valid4 = 1'b1; load_data4 = 4'hC;
    tick();
    load_data4 = 4'h3;
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) load_valid4 = 1'b0;
      #1;
      checks++;
      if ({sout_valid4, sout4, sout_first4, sout_last4, load_ready4} !==
          {1'b1, exp_bits[i], 1'(i % 4 == 0), 1'(i % 4 == 3), 1'(i % 4 == 3)})
        $display("FAIL b2b_bit%0d: valid/sout/first/last/ready=%b required %b", i,
                 {sout_valid4, sout4, sout_first4, sout_last4, load_ready4},
                 {1'b1, exp_bits[i], 1'(i % 4 == 0), 1'(i % 4 == 3), 1'(i % 4 == 3)});
      else passed++;
      tick();
    end
    checks++;
    if ({sout_valid4, sout4} !== 2'b00)
      $display("FAIL b2b_idle: valid/sout=%b required 00", {sout_valid4, sout4});
    else passed++;
  endtask

  task automatic test_stall();
    logic exp_bits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    shift_en = 1'b0; load_valid4 = 1'b1; load_data4 = 4'b1001;
    tick();
    load_valid4 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      shift_en = (j % 3 == 2);
      if (j == 1) load_data4 = 4'h6;
      #1;
      checks++;
      if ({sout_valid4, sout4, sout_first4, sout_last4, load_ready4} !==
          {1'b1, exp_bits[j / 3], 1'(j / 3 == 0), 1'(j / 3 == 3), 1'(j == 11)})
        $display("FAIL stall_cyc%0d: valid/sout/first/last/ready=%b required %b", j,
                 {sout_valid4, sout4, sout_first4, sout_last4, load_ready4},
                 {1'b1, exp_bits[j / 3], 1'(j / 3 == 0), 1'(j / 3 == 3), 1'(j == 11)});
      else passed++;
      tick();
    end
    checks++;
    if ({sout_valid4, sout4} !== 2'b00)
      $display("FAIL stall_idle: valid/sout=%b required 00", {sout_valid4, sout4});
    else passed++;
  endtask

  task automatic test_midframe_reset();
    logic exp_bits [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    shift_en = 1'b1; load_valid4 = 1'b1; load_data4 = 4'hF;
    tick();
    load_valid4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({sout_valid4, sout4, sout_first4, sout_last4, load_ready4} !== 5'b00001)
      $display("FAIL midrst_abort: valid/sout/first/last/ready=%b required 00001",
               {sout_valid4, sout4, sout_first4, sout_last4, load_ready4});
    else passed++;
    load_valid4 = 1'b1; load_data4 = 4'h5;
    tick();
    load_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sout_valid4, sout4, sout_first4, sout_last4} !==
          {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 3)})
        $display("FAIL midrst_bit%0d: valid/sout/first/last=%b required %b", i,
                 {sout_valid4, sout4, sout_first4, sout_last4},
                 {1'b1, exp_bits[i], 1'(i == 0), 1'(i == 3)});
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0;
    load_valid4 = 1'b0; load_data4 = 4'h0;
    load_valid8 = 1'b0; load_data8 = 8'h00;
    #1;
    test_reset();
    test_single_msb();
    test_lsb_loopback();
    test_back_to_back();
    test_stall();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_piso_serializer
